// File: rtl/spike_rate_decoder.sv
// Per-channel spike rate counter over a window of enabled cycles. Each completed
// window is snapshotted and streamed out one channel per word on valid/ready.
module spike_rate_decoder #(
    parameter int N_CH     = 8,
    parameter int WIN_LOG2 = 5,
    parameter int RATE_W   = 8,
    localparam int CH_W    = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_CH-1:0]   spike_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [RATE_W-1:0] out_rate,
    output logic              out_last,
    output logic              overrun
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIN_LOG2-1:0] r_win;
    logic [RATE_W-1:0]   r_cnt  [N_CH];
    logic [RATE_W-1:0]   r_snap [N_CH];
    logic [RATE_W-1:0]   w_final[N_CH];
    logic [CH_W-1:0]     r_ch;
    logic                r_overrun;

    logic w_win_end;
    logic w_xfer;
    logic w_last_xfer;
    logic w_can_load;
    logic w_load;

    function automatic logic [RATE_W-1:0] sat_inc(input logic [RATE_W-1:0] c,
                                                   input logic s);
        if (s && (c != {RATE_W{1'b1}}))
            return c + RATE_W'(1);
        return c;
    endfunction

    assign w_win_end   = en && (r_win == {WIN_LOG2{1'b1}});
    assign w_xfer      = (r_state == SEND) && out_ready;
    assign w_last_xfer = w_xfer && (r_ch == CH_W'(N_CH - 1));
    // A window ending on the final transfer reloads without flagging overrun.
    assign w_can_load  = (r_state == IDLE) || w_last_xfer;
    assign w_load      = w_win_end && w_can_load;

    always_comb begin
        for (int i = 0; i < N_CH; i++)
            w_final[i] = sat_inc(r_cnt[i], spike_in[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win <= '0;
        end else if (en) begin
            r_win <= r_win + WIN_LOG2'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++)
                r_cnt[i] <= '0;
        end else if (en) begin
            for (int i = 0; i < N_CH; i++)
                r_cnt[i] <= w_win_end ? '0 : w_final[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++)
                r_snap[i] <= '0;
        end else if (w_load) begin
            for (int i = 0; i < N_CH; i++)
                r_snap[i] <= w_final[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch <= '0;
        end else if (w_load) begin
            r_ch <= '0;
        end else if (w_xfer && !w_last_xfer) begin
            r_ch <= r_ch + CH_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_win_end && !w_can_load) begin
            r_overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_load) w_state_nxt = SEND;
            SEND: begin
                if (w_load)
                    w_state_nxt = SEND;
                else if (w_last_xfer)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (r_state == SEND);
        out_last  = (r_state == SEND) && (r_ch == CH_W'(N_CH - 1));
        out_ch    = r_ch;
        out_rate  = r_snap[r_ch];
        overrun   = r_overrun;
    end

endmodule
